// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states, Booth
// operation encoding and the radix-2 recode helper.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpNop,
    OpAdd,
    OpSub
  } booth_op_e;

  // Radix-2 Booth recode of the current multiplier bit and the previous one.
  function automatic booth_op_e booth_recode(input logic q0, input logic e);
    booth_op_e op;
    case ({q0, e})
      2'b10:   op = OpSub;
      2'b01:   op = OpAdd;
      default: op = OpNop;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then arithmetic right shift of {acc,q}.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             e,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             e_next
);

  logic [WIDTH:0] sum;

  // Recode, add/subtract, then shift the combined register right by one.
  always_comb begin
    sum = acc;
    case (booth_recode(q[0], e))
      OpAdd:   sum = acc + m;
      OpSub:   sum = acc - m;
      default: sum = acc;
    endcase
    {acc_next, q_next} = {sum[WIDTH], sum, q[WIDTH-1:1]};
    e_next             = q[0];
  end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both
// sides. One recode/add/shift iteration per clock through a shared booth_step.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand at the handshake jumps
// straight to DONE with a zero product (same result, shorter latency).
module booth_seq_mult_ctrl
  import booth_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  state_e state_q, state_d;

  // acc is one bit wider than the operands so -M of the most negative b fits.
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     q_q;
  logic                 e_q;
  logic [WIDTH:0]       m_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       acc_s;
  logic [WIDTH-1:0]     q_s;
  logic                 e_s;

  logic                 load;
  logic                 step_en;
  logic                 last_step;
  logic                 zero_done;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .e        (e_q),
    .m        (m_q),
    .acc_next (acc_s),
    .q_next   (q_s),
    .e_next   (e_s)
  );

  // Handshake outputs are masked during reset so nothing transfers in that cycle.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone) && !rst;
  assign busy      = (state_q != StIdle);
  assign product   = product_q;

  // Next-state and datapath control decode.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step_en   = 1'b0;
    last_step = 1'b0;
    zero_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          load = 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            zero_done = 1'b1;
            state_d   = StDone;
          end else begin
            state_d = StRun;
          end
`else
          state_d = StRun;
`endif
        end
      end
      StRun: begin
        step_en = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, per-cycle Booth iteration and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      q_q       <= '0;
      e_q       <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      q_q   <= a;
      e_q   <= 1'b0;
      m_q   <= {b[WIDTH-1], b};
      cnt_q <= '0;
      if (zero_done) begin
        product_q <= '0;
      end
    end else if (step_en) begin
      acc_q <= acc_s;
      q_q   <= q_s;
      e_q   <= e_s;
      cnt_q <= cnt_q + CNT_W'(1);
      // acc_s MSB only duplicates the sign after the final shift.
      if (last_step) begin
        product_q <= {acc_s[WIDTH-1:0], q_s};
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Scoreboard bench for booth_seq_mult_ctrl: the driver pushes the expected
// product and due cycle on each accepted request; a monitor pops on transfer.
module tb_booth_seq_mult_ctrl;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   product;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;
  exp_t sb[$];

  booth_seq_mult_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom) : ready_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none (t=%0t)", name, $time);
  endtask

  // Reference: plain signed integer product, truncated to the product width.
  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x,
                                             input logic signed [W-1:0] y);
    int xi;
    int yi;
    xi = x;
    yi = y;
    return (2 * W)'(xi * yi);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("send_timeout");
    else if (push) sb.push_back('{p: ref_mul(x, y), due: cyc + ref_lat(x, y)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("drain_timeout");
  endtask

  // Monitor: latency on rising out_valid, product on transfer, stall stability.
  initial begin
    logic           prev_ov;
    logic           hold;
    logic [2*W-1:0] held;
    exp_t           e;
    prev_ov = 1'b0;
    hold    = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
        hold    = 1'b0;
      end else begin
        check("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
        if (hold) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_product", 64'(product), 64'(held));
        end
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) fail("unexpected_valid");
          else check("latency", 64'(cyc), 64'(sb[0].due));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_transfer");
          end else begin
            e = sb.pop_front();
            check("product", 64'(product), 64'(e.p));
            n_out++;
          end
        end
        hold    = out_valid && !out_ready;
        held    = product;
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    int n0;
    bit seen;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Directed products, including sign and boundary cases.
    ready_force = 1'b1;
    send(4'd3, 4'd5, 1'b1);
    send(4'hD, 4'd5, 1'b1);
    send(4'h8, 4'h8, 1'b1);
    send(4'd7, 4'h8, 1'b1);
    send(4'd0, 4'hB, 1'b1);
    send(4'd6, 4'd0, 1'b1);
    wait_idle();

    // Backpressure: result held for 10 cycles, in_valid pulses ignored.
    ready_force = 1'b0;
    @(negedge clk);
    n0 = n_out;
    send(4'hF, 4'hF, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("bp_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    check("bp_product", 64'(product), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    ready_force = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("bp_transfers", 64'(n_out - n0), 64'd1);

    // Reset two cycles after a handshake discards the in-flight result.
    send(4'd5, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_in_ready", 64'(in_ready), 64'd0);
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", 64'(in_ready), 64'd1);
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    check("after_rst_product", 64'(product), 64'd0);
    check("after_rst_busy", 64'(busy), 64'd0);
    send(4'd2, 4'hD, 1'b1);
    wait_idle();

    // All operand pairs with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        send(W'(i), W'(j), 1'b1);
      end
    end
    wait_idle();
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench never hangs.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
